// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID-stage request fields in, EX forwarding and stall/flush controls out
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
);
  logic ID_valid;
  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic ID_UseRs;
  logic ID_UseRt;
  logic ID_RegWrite;
  logic ID_MemRead;
  logic [REG_AW-1:0] ID_WriteAddr;
  logic EX_BranchTaken;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic Stall;
  logic Flush_IFID;
  logic Bubble_IDEX;
  logic [CNT_W-1:0] StallCount;
  modport master (
    output ID_valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemRead, ID_WriteAddr, EX_BranchTaken,
    input ForwardA, ForwardB, Stall, Flush_IFID, Bubble_IDEX, StallCount
  );
  modport slave (
    input ID_valid, ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemRead, ID_WriteAddr, EX_BranchTaken,
    output ForwardA, ForwardB, Stall, Flush_IFID, Bubble_IDEX, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: EX-stage forwarding, load-use stall and branch flush control for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic use_rs;
    logic use_rt;
    logic reg_write;
    logic mem_read;
    logic [REG_AW-1:0] wa;
  } stage_t;
  stage_t id, ex, mem, wb;
  logic lu, stall, bubble;
  logic [CNT_W-1:0] cnt;
  logic unused;
  // MEM wins over WB; loads in MEM have no data yet, so they never forward
  function automatic logic [1:0] fwd(input stage_t e, input stage_t m, input stage_t w,
                                     input logic [REG_AW-1:0] src, input logic en);
    return !(e.valid && en && src != '0) ? 2'b00 :
           (m.valid && m.reg_write && !m.mem_read && m.wa == src) ? 2'b10 :
           (w.valid && w.reg_write && w.wa == src) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = bus.ID_valid && ex.valid && ex.mem_read && ex.wa != '0 &&
         ((bus.ID_UseRs && bus.ID_rs == ex.wa) || (bus.ID_UseRt && bus.ID_rt == ex.wa));
    stall = lu && !bus.EX_BranchTaken;
    bubble = stall || bus.EX_BranchTaken;
    id = '{valid: bus.ID_valid && !bubble, rs: bus.ID_rs, rt: bus.ID_rt, use_rs: bus.ID_UseRs,
           use_rt: bus.ID_UseRt, reg_write: bus.ID_RegWrite, mem_read: bus.ID_MemRead, wa: bus.ID_WriteAddr};
    bus.ForwardA = fwd(ex, mem, wb, ex.rs, ex.use_rs);
    bus.ForwardB = fwd(ex, mem, wb, ex.rt, ex.use_rt);
    bus.Stall = stall;
    bus.Flush_IFID = bus.EX_BranchTaken;
    bus.Bubble_IDEX = bubble;
    bus.StallCount = cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      cnt <= '0;
    end else begin
      ex <= id;
      mem <= ex;
      wb <= mem;
      if (stall && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end
  // source fields of MEM/WB are carried as shadow state only
  assign unused = ^{mem, wb};
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed hazard scenarios checked through an expectation queue and a negedge monitor
module tb_pipeline_hazard_ctrl;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) bus4 ();
  assign bus4.ID_valid = bus.ID_valid;
  assign bus4.ID_rs = bus.ID_rs;
  assign bus4.ID_rt = bus.ID_rt;
  assign bus4.ID_UseRs = bus.ID_UseRs;
  assign bus4.ID_UseRt = bus.ID_UseRt;
  assign bus4.ID_RegWrite = bus.ID_RegWrite;
  assign bus4.ID_MemRead = bus.ID_MemRead;
  assign bus4.ID_WriteAddr = bus.ID_WriteAddr;
  assign bus4.EX_BranchTaken = bus.EX_BranchTaken;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct packed {
    int cyc;
    logic [1:0] fa;
    logic [1:0] fb;
    logic st;
    logic fl;
    logic bu;
    logic [15:0] c;
    logic [3:0] c4;
  } exp_t;
  exp_t q[$];
  string nq[$];
  exp_t me;
  string mn;
  logic [26:0] got, want;

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      mn = nq.pop_front();
      got = {bus.ForwardA, bus.ForwardB, bus.Stall, bus.Flush_IFID, bus.Bubble_IDEX, bus.StallCount, bus4.StallCount};
      want = {me.fa, me.fb, me.st, me.fl, me.bu, me.c, me.c4};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b bubble=%b cnt=%0d cnt4=%0d, expected fa=%b fb=%b stall=%b flush=%b bubble=%b cnt=%0d cnt4=%0d",
                 mn, bus.ForwardA, bus.ForwardB, bus.Stall, bus.Flush_IFID, bus.Bubble_IDEX, bus.StallCount, bus4.StallCount,
                 me.fa, me.fb, me.st, me.fl, me.bu, me.c, me.c4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic rw, input logic mr, input logic [4:0] wa, input logic br);
    bus.ID_valid = v;
    bus.ID_rs = rs;
    bus.ID_rt = rt;
    bus.ID_UseRs = urs;
    bus.ID_UseRt = urt;
    bus.ID_RegWrite = rw;
    bus.ID_MemRead = mr;
    bus.ID_WriteAddr = wa;
    bus.EX_BranchTaken = br;
  endtask

  task automatic nop();             drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic add3();            drv(1, 1, 2, 1, 1, 1, 0, 3, 0); endtask
  task automatic sub3(input logic [4:0] rs); drv(1, rs, 5, 1, 1, 1, 0, 4, 0); endtask
  task automatic lw2();             drv(1, 1, 0, 1, 0, 1, 1, 2, 0); endtask
  task automatic add6(input logic br); drv(1, 2, 2, 1, 1, 1, 0, 6, br); endtask

  task automatic expect_out(input string n, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic fl, input logic bu, input int c);
    exp_t e;
    e.cyc = cyc;
    e.fa = fa;
    e.fb = fb;
    e.st = st;
    e.fl = fl;
    e.bu = bu;
    e.c = 16'(c);
    e.c4 = (c > 15) ? 4'hf : 4'(c);
    q.push_back(e);
    nq.push_back(n);
  endtask

  initial begin
    nop();
    tick(); expect_out("rst_init", 0, 0, 0, 0, 0, 0);
    tick(); reset = 1; expect_out("rst_release", 0, 0, 0, 0, 0, 0);
    // ADD $3 ; SUB $4,$3,$5 back-to-back, then with a NOP between
    tick(); add3();    expect_out("add_id", 0, 0, 0, 0, 0, 0);
    tick(); sub3(3);   expect_out("add_ex", 0, 0, 0, 0, 0, 0);
    tick(); nop();     expect_out("fwd_mem", 2'b10, 0, 0, 0, 0, 0);
    tick(); add3();    expect_out("gap_add", 0, 0, 0, 0, 0, 0);
    tick(); nop();     expect_out("gap_nop", 0, 0, 0, 0, 0, 0);
    tick(); sub3(3);   expect_out("gap_sub", 0, 0, 0, 0, 0, 0);
    tick(); nop();     expect_out("fwd_wb", 2'b01, 0, 0, 0, 0, 0);
    // two writers of $3: MEM copy must win
    tick(); add3();    expect_out("prio_a1", 0, 0, 0, 0, 0, 0);
    tick(); add3();    expect_out("prio_a2", 0, 0, 0, 0, 0, 0);
    tick(); sub3(3);   expect_out("prio_sub", 0, 0, 0, 0, 0, 0);
    tick(); nop();     expect_out("mem_prio", 2'b10, 0, 0, 0, 0, 0);
    // same with destination $0
    tick(); drv(1, 1, 2, 1, 1, 1, 0, 0, 0); expect_out("r0_a1", 0, 0, 0, 0, 0, 0);
    tick(); drv(1, 1, 2, 1, 1, 1, 0, 0, 0); expect_out("r0_a2", 0, 0, 0, 0, 0, 0);
    tick(); sub3(0);   expect_out("r0_sub", 0, 0, 0, 0, 0, 0);
    tick(); nop();     expect_out("reg0_nofwd", 0, 0, 0, 0, 0, 0);
    // load-use: one stall, then WB forwarding on both operands
    tick(); lw2();     expect_out("lu_lw", 0, 0, 0, 0, 0, 0);
    tick(); add6(0);   expect_out("lu_stall", 0, 0, 1, 0, 1, 0);
    tick();            expect_out("lu_bubble", 0, 0, 0, 0, 0, 1);
    tick(); nop();     expect_out("lu_fwd", 2'b01, 2'b01, 0, 0, 0, 1);
    // branch taken while load-use pending
    tick(); lw2();     expect_out("br_lw", 0, 0, 0, 0, 0, 1);
    tick(); add6(1);   expect_out("br_flush", 0, 0, 0, 1, 1, 1);
    tick(); nop();     expect_out("br_cnt", 0, 0, 0, 0, 0, 1);
    // shamt shift: rs unused
    tick(); drv(1, 1, 2, 1, 1, 1, 0, 7, 0); expect_out("sll_add", 0, 0, 0, 0, 0, 1);
    tick(); drv(1, 7, 2, 0, 1, 1, 0, 8, 0); expect_out("sll_id", 0, 0, 0, 0, 0, 1);
    tick(); nop();     expect_out("no_rs_fwd", 0, 0, 0, 0, 0, 1);
    tick(); drv(1, 1, 0, 1, 0, 1, 1, 9, 0); expect_out("sll_lw", 0, 0, 0, 0, 0, 1);
    tick(); drv(1, 9, 0, 0, 1, 1, 0, 8, 0); expect_out("lu_no_rs", 0, 0, 0, 0, 0, 1);
    tick(); lw2();     expect_out("sll_rt0", 0, 0, 0, 0, 0, 1);
    // reset asserted mid-stall, checked before the next edge
    tick(); add6(0); #1; reset = 0; expect_out("rst_async", 0, 0, 0, 0, 0, 0);
    tick();            expect_out("rst_hold", 0, 0, 0, 0, 0, 0);
    tick(); reset = 1; nop();
    for (int i = 1; i <= 20; i++) begin
      tick(); lw2();
      tick(); add6(0); expect_out("sat_stall", 0, 0, 1, 0, 1, i - 1);
      tick();
    end
    tick(); nop();     expect_out("sat_end", 2'b01, 2'b01, 0, 0, 0, 20);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the EX-stage ALU datapath of the 5-stage MIPS pipeline.
- Keeps its own shadow copy of the destination/control fields of the instructions in EX, MEM and WB.
- From these it produces the ForwardA/ForwardB operand-select codes consumed by the EX stage, the load-use stall, and the bubble/flush controls.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_valid  in  1  instruction in ID is real (not bubble).
- ID_rs  in  REG_AW  ID source register A.
- ID_rt  in  REG_AW  ID source register B.
- ID_UseRs  in  1  ID reads rs through the ALU A path (0 when ALUSrc1 selects shamt).
- ID_UseRt  in  1  ID reads rt through the ALU B path (0 when ALUSrc2 selects immediate).
- ID_RegWrite  in  1  ID instruction writes the register file.
- ID_MemRead  in  1  ID instruction is a load.
- ID_WriteAddr  in  REG_AW  ID destination register.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- ForwardA  out  2  EX operand A select: 00 register, 01 MEM/WB data, 10 EX/MEM data.
- ForwardB  out  2  EX operand B select, same encoding.
- Stall  out  1  hold PC and IF/ID this cycle.
- Flush_IFID  out  1  clear IF/ID at next edge.
- Bubble_IDEX  out  1  load a bubble into ID/EX at next edge.
- StallCount  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Shadow stages EX, MEM, WB each hold: valid, rs, rt, UseRs, UseRt, RegWrite, MemRead, WriteAddr.
- Reset (reset=0, asynchronous):
  - all shadow valid=0 and StallCount=0.
  - Resulting outputs: ForwardA=ForwardB=00, Stall=0, Flush_IFID=0, Bubble_IDEX=0.
  - Reset mid-stall cancels the stall immediately.
- Register shift at each rising edge:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields with valid=ID_valid, except when Bubble_IDEX=1: EX.valid<=0.
- Forwarding (combinational from shadow state, applies to the instruction in EX). ForwardA, if EX.valid & EX.UseRs & EX.rs!=0:
  - 10 if MEM.valid & MEM.RegWrite & !MEM.MemRead & MEM.WriteAddr==EX.rs;
  - else 01 if WB.valid & WB.RegWrite & WB.WriteAddr==EX.rs;
  - else 00.
  - MEM has priority over WB (newest value wins).
- ForwardB: identical rule using EX.rt and EX.UseRt.
- Register $0 is never forwarded.
- Code 11 is never driven.
- Load-use hazard:
  - Condition: LU = ID_valid & EX.valid & EX.MemRead & EX.WriteAddr!=0 & ((ID_UseRs & ID_rs==EX.WriteAddr) | (ID_UseRt & ID_rt==EX.WriteAddr)).
  - Stall=LU & !EX_BranchTaken.
  - Exactly one stall cycle per load: after the edge the load is in MEM, and its data is forwarded from WB via 01 in the following cycle.
- Branch flush: EX_BranchTaken=1 → Flush_IFID=1, Bubble_IDEX=1, Stall=0. Flush overrides a simultaneous load-use stall.
- Bubble_IDEX = Stall | EX_BranchTaken.
- StallCount increments on each edge where Stall=1; it holds at all-ones (no wrap).
- All outputs other than StallCount are combinational from current shadow state and ID/EX inputs. There are no registered outputs, so decisions take effect at the next edge.

Test Plan:
- Reset with reset=0 mid-run → all shadow cleared; ForwardA/B=00, Stall=0, StallCount=0 asynchronously, before any clock edge.
- ADD $3 then SUB $4,$3,$5 back-to-back → with SUB in EX: ForwardA=10, ForwardB=00. Same pair separated by one NOP → ForwardA=01.
- ADD $3 ; ADD $3 ; SUB uses $3 → ForwardA=10 (MEM priority over WB). Repeat with destination $0 → ForwardA=00.
- LW $2 then ADD $6,$2,$2 → exactly one cycle Stall=1 and Bubble_IDEX=1; next cycle, with ADD in EX: ForwardA=ForwardB=01; StallCount=1.
- LW $2 in EX, dependent instruction in ID, and EX_BranchTaken=1 in the same cycle → Stall=0, Flush_IFID=1, Bubble_IDEX=1; StallCount unchanged.
- ID instruction with UseRs=0 (shamt shift) and rs matching a pending write → ForwardA=00. Force CNT_W=4 and issue 20 load-use stalls → StallCount saturates at 15.
